serial_adder: RTL and testbench
===============================

# serial_adder

- Bit-serial ripple adder for WIDTH-bit operands plus a carry-in.
- Computes one sum bit per clock through a single one-bit full-adder cell, LSB first, with a registered carry between cycles.
- Sits in front of the one-bit adder datapath and wraps it in a valid/ready handshake.
- Trades latency for area: one cell replaces WIDTH cells.

## Interface
Parameters:
- WIDTH, 8, operand and sum width; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result bits {a+b+cin}[WIDTH-1:0]
- cout  output  1  carry-out, bit WIDTH of a+b+cin
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load a_sh=a, b_sh=b, carry=cin, cnt=0; go to ADD.
- ADD, each cycle:
  - Cell inputs are a_sh[0], b_sh[0], carry; outputs s, c.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - carry <= c; cnt <= cnt+1.
  - When cnt == WIDTH-1: load result registers sum and cout from the final shifted value and c; go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE.
  - in_ready = 0; in_valid is ignored.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded directly from registered state.
- sum and cout change only on the ADD->DONE transition and hold through IDLE and ADD until the next completion.
- Arithmetic is modulo 2^(WIDTH+1): {cout, sum} = a + b + cin, exact and unsigned.
- The counter is $clog2(WIDTH) bits wide.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, all internal registers 0.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge.
- Minimum issue interval is WIDTH+2 clocks: WIDTH in ADD, 1 in DONE with out_ready high, 1 in IDLE.
- Back-pressure: out_valid, sum, cout and ovf are held stable for any number of cycles while out_ready = 0.
- out_ready while not in DONE has no effect.
- Reset asserted in any state, including mid-ADD:
  - Returns to IDLE immediately (asynchronous).
  - The in-flight operation is discarded; no out_valid is produced for it.
- Operands are sampled only on the accepting edge. Changes on a, b or cin afterwards do not affect the result.

## Configuration
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Port ovf exists.
  - Carry-in to the MSB is captured at cnt == WIDTH-1.
  - ovf = carry_into_MSB ^ cout, loaded with sum/cout and held identically.
  - Reset value 0.
- Undefined: no ovf port, no extra register. Behaviour is otherwise identical.

## Structure
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADD, DONE} sa_state_t
  - localparam SA_DEFAULT_WIDTH = 8
- One sub-module, serial_fa_cell: purely combinational one-bit full adder (a, b, cin -> sum, cout), instantiated once.
- All state lives in serial_adder.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 -> out_valid 8 clocks after accept; sum=0x00, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- OVF_EN, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Back-pressure: out_ready=0 for 5 clocks after out_valid with a=0x3C, b=0x05 -> sum=0x41 held, in_ready=0, a pulse on in_valid is not accepted. out_ready=1 -> IDLE next clock.
- Reset mid-ADD: assert rst_n=0 at cnt=3 -> out_valid=0, in_ready=1, sum=0. Next op a=0x12, b=0x34 -> sum=0x46, cout=0.
- WIDTH=2, exhaustive 32 combinations of a, b, cin with random out_ready stalls -> {cout, sum} == a+b+cin every time; issue interval never below 4 clocks.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Imported by serial_adder and serial_fa_cell.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder; the single arithmetic cell the serial adder reuses every cycle.
module serial_fa_cell
  import serial_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: WIDTH-bit a + b + cin, one sum bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds valid and data stable until that edge.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] sum_cat;

  serial_fa_cell u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (cell_s),
    .cout_o (cell_c)
  );

  // Partial sum keeps only WIDTH-1 bits; the newest bit completes the word.
  assign sum_cat = {cell_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_sh_d = sum_cat[WIDTH-1:1];
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = cell_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_cat;
          cout_d  = cell_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this last step.
          ovf_d   = carry_q ^ cell_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random ops and a WIDTH=2 exhaustive sweep.
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] dbg8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
  logic       ovf2;
`endif

  logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2;
  logic [1:0] a2, b2, sum2;
  logic [1:0] dbg2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];
  logic [2:0] exp2_q[$];
`ifdef SERIAL_ADDER_OVF_EN
  logic       exp_ovf_q[$];
`endif

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid8),
    .in_ready    (in_ready8),
    .a           (a8),
    .b           (b8),
    .cin         (cin8),
    .out_valid   (out_valid8),
    .out_ready   (out_ready8),
    .sum         (sum8),
    .cout        (cout8),
    .dbg_state_o (dbg8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf         (ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .a           (a2),
    .b           (b2),
    .cin         (cin2),
    .out_valid   (out_valid2),
    .out_ready   (out_ready2),
    .sum         (sum2),
    .cout        (cout2),
    .dbg_state_o (dbg2)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf         (ovf2)
`endif
  );

  // Clock / reset / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic
  function automatic logic [8:0] ref_add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int s;
    s = int'(ta) + int'(tb) + int'(tc);
    return s[8:0];
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  function automatic logic ref_ovf8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    int s;
    s = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    return (s > 127) || (s < -128);
  endfunction
`endif

  // Driver: one WIDTH=8 operation, with `stall` cycles of back-pressure once the result is up.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input int stall, input string tag);
    int         g;
    logic [8:0] exp;
    logic [8:0] held;
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1; out_ready8 = 1'b0;
    g = 0;
    while (in_ready8 !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 50) begin
      failures++;
      $display("FAIL %s_accept got in_ready=%b want=1", tag, in_ready8);
      in_valid8 = 1'b0;
      return;
    end
    exp_q.push_back(ref_add8(ta, tb, tc));
`ifdef SERIAL_ADDER_OVF_EN
    exp_ovf_q.push_back(ref_ovf8(ta, tb, tc));
`endif
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    g = 0;
    while (out_valid8 !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g != 8) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=8", tag, g);
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      held = {cout8, sum8};
      checks++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || held !== exp) begin
        failures++;
        $display("FAIL %s_hold cycle=%0d got valid=%b ready=%b res=%h want valid=1 ready=0 res=%h",
                 tag, i, out_valid8, in_ready8, held, exp);
      end
      in_valid8 = (i == 1);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    checks++;
    if ({cout8, sum8} !== exp) begin
      failures++;
      $display("FAIL %s_result got=%h want=%h", tag, {cout8, sum8}, exp);
    end
`ifdef SERIAL_ADDER_OVF_EN
    begin
      logic eo;
      eo = exp_ovf_q.pop_front();
      checks++;
      if (ovf8 !== eo) begin
        failures++;
        $display("FAIL %s_ovf got=%b want=%b", tag, ovf8, eo);
      end
    end
`endif
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL %s_release got valid=%b ready=%b want valid=0 ready=1", tag, out_valid8, in_ready8);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs8 got ready=%b valid=%b want ready=1 valid=0", in_ready8, out_valid8);
    end
    checks++;
    if ({cout8, sum8} !== 9'h000) begin
      failures++;
      $display("FAIL reset_res8 got=%h want=000", {cout8, sum8});
    end
    checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || {cout2, sum2} !== 3'b000) begin
      failures++;
      $display("FAIL reset_w2 got ready=%b valid=%b res=%b want ready=1 valid=0 res=000",
               in_ready2, out_valid2, {cout2, sum2});
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b want=0", ovf8);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_directed();
    run_op8(8'h00, 8'h00, 1'b0, 0, "zero");
    run_op8(8'hFF, 8'h01, 1'b0, 0, "wrap");
    run_op8(8'hFF, 8'hFF, 1'b1, 1, "max");
    run_op8(8'hA5, 8'h5A, 1'b1, 0, "alt");
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    run_op8(8'h7F, 8'h01, 1'b0, 0, "ovf_pos");
    run_op8(8'h80, 8'h80, 1'b0, 2, "ovf_neg");
    run_op8(8'h40, 8'h3F, 1'b0, 0, "ovf_none");
  endtask
`endif

  task automatic test_back_pressure();
    run_op8(8'h3C, 8'h05, 1'b0, 5, "bp");
  endtask

  task automatic test_reset_mid_add();
    int seen;
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || {cout8, sum8} !== 9'h000) begin
      failures++;
      $display("FAIL midrst_async got valid=%b ready=%b res=%h want valid=0 ready=1 res=000",
               out_valid8, in_ready8, {cout8, sum8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid8 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_no_result got valid_cycles=%0d want=0", seen);
    end
    run_op8(8'h12, 8'h34, 1'b0, 0, "after_rst");
  endtask

  task automatic test_random8();
    for (int i = 0; i < 10; i++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), "rand");
    end
  endtask

  // WIDTH=2: every a, b, cin with random consumer stalls; in_valid held high to probe the issue interval.
  task automatic test_exhaustive_w2();
    fork
      begin : drv
        int g;
        int acc;
        int last_acc;
        logic [4:0] vv;
        last_acc = 0;
        @(negedge clk);
        for (int v = 0; v < 32; v++) begin
          vv = 5'(v);
          a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0]; in_valid2 = 1'b1;
          g = 0;
          while (in_ready2 !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
          end
          if (g >= 100) begin
            checks++;
            failures++;
            $display("FAIL w2_accept op=%0d got in_ready=%b want=1", v, in_ready2);
            break;
          end
          exp2_q.push_back(3'(int'(vv[4:3]) + int'(vv[2:1]) + int'(vv[0])));
          @(negedge clk);
          acc = cyc;
          if (v > 0) begin
            checks++;
            if (acc - last_acc < 4) begin
              failures++;
              $display("FAIL w2_interval op=%0d got=%0d want>=4", v, acc - last_acc);
            end
          end
          last_acc = acc;
        end
        in_valid2 = 1'b0;
      end
      begin : mon
        int got;
        int g;
        logic [2:0] e;
        got = 0;
        g = 0;
        while (got < 32 && g < 3000) begin
          @(negedge clk);
          g++;
          if (out_valid2 === 1'b1) begin
            out_ready2 = ($urandom_range(0, 2) != 0);
            if (out_ready2) begin
              checks++;
              if (exp2_q.size() == 0) begin
                failures++;
                $display("FAIL w2_unexpected got=%b want=none", {cout2, sum2});
              end else begin
                e = exp2_q.pop_front();
                if ({cout2, sum2} !== e) begin
                  failures++;
                  $display("FAIL w2_result n=%0d got=%b want=%b", got, {cout2, sum2}, e);
                end
              end
              got++;
            end
          end else begin
            out_ready2 = 1'($urandom_range(0, 1));
          end
        end
        out_ready2 = 1'b0;
        checks++;
        if (got != 32) begin
          failures++;
          $display("FAIL w2_count got=%0d want=32", got);
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_back_pressure();
    test_reset_mid_add();
    test_random8();
    test_exhaustive_w2();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
